// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel stage for a VGA pipeline: turns beam position into a registered
// 3-bit RGB pixel, keeps the sync outputs aligned, and switches patterns on frame boundaries.
module vga_pattern_gen #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int BOX_SIZE        = 32,
    parameter int CHK_LOG2        = 5,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x_in,
    input  logic [8:0] y_in,
    input  logic       in_display,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       mode_next,
    output logic [2:0] pixel,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [1:0] mode,
    output logic [7:0] frame_count
);

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_BOX   = 2'd2,
        PAT_CYCLE = 2'd3
    } pattern_t;

    localparam logic        SYNC_IDLE = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [9:0]  XMAX      = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [8:0]  YMAX      = 9'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] BOX_W_X   = 11'(BOX_SIZE);
    localparam logic [9:0]  BOX_W_Y   = 10'(BOX_SIZE);
    localparam int          BAR_WIDTH = H_ACTIVE / 8;

    pattern_t   pattern_reg, pattern_next;
    logic       pending_reg, pending_next;
    logic [7:0] frame_count_reg, frame_count_next;
    logic [9:0] box_x_reg, box_x_next;
    logic [8:0] box_y_reg, box_y_next;
    logic       dir_x_reg, dir_x_next;
    logic       dir_y_reg, dir_y_next;
    logic       vsync_prev_reg;
    logic       hsync_out_reg, vsync_out_reg;
    logic [2:0] pixel_reg, pixel_next;

    logic       frame_tick;
    logic [6:0] bar_hit;
    logic [2:0] bar_idx;
    logic [10:0] box_x_end;
    logic [9:0]  box_y_end;
    logic        in_box;

    // A tick marks the first cycle in which vsync becomes active.
    assign frame_tick = (vsync_in != SYNC_IDLE) && (vsync_prev_reg == SYNC_IDLE);

    genvar gi;
    generate
        for (gi = 1; gi < 8; gi++) begin : g_bar
            assign bar_hit[gi-1] = (x_in >= 10'(gi * BAR_WIDTH));
        end
    endgenerate

    always_comb begin
        bar_idx = 3'd0;
        for (int k = 0; k < 7; k++) begin
            bar_idx = bar_idx + {2'b00, bar_hit[k]};
        end
    end

    assign box_x_end = {1'b0, box_x_reg} + BOX_W_X;
    assign box_y_end = {1'b0, box_y_reg} + BOX_W_Y;
    assign in_box    = ({1'b0, x_in} >= {1'b0, box_x_reg}) && ({1'b0, x_in} < box_x_end) &&
                       ({1'b0, y_in} >= {1'b0, box_y_reg}) && ({1'b0, y_in} < box_y_end);

    // Pixel uses the currently registered mode/box/frame state; updates land one cycle later.
    always_comb begin
        pixel_next = 3'd0;
        if (in_display) begin
            case (pattern_reg)
                PAT_BARS:  pixel_next = 3'd7 - bar_idx;
                PAT_CHECK: pixel_next = (x_in[CHK_LOG2] ^ y_in[CHK_LOG2]) ? 3'b111 : 3'b000;
                PAT_BOX:   pixel_next = in_box ? 3'b111 : 3'b001;
                PAT_CYCLE: pixel_next = frame_count_reg[7:5];
                default:   pixel_next = 3'd0;
            endcase
        end
    end

    // Mode control: requests collapse into one pending flag, consumed only at a frame tick.
    always_comb begin
        pattern_next     = pattern_reg;
        pending_next     = pending_reg;
        frame_count_next = frame_count_reg;
        if (frame_tick) begin
            frame_count_next = frame_count_reg + 8'd1;
            pending_next     = 1'b0;
            if (pending_reg || mode_next) begin
                pattern_next = pattern_t'(pattern_reg + 2'd1);
            end
        end else if (mode_next) begin
            pending_next = 1'b1;
        end
    end

    always_comb begin
        box_x_next = box_x_reg;
        box_y_next = box_y_reg;
        dir_x_next = dir_x_reg;
        dir_y_next = dir_y_reg;
        if (frame_tick) begin
            if (dir_x_reg) begin
                if (box_x_reg == XMAX) begin
                    dir_x_next = 1'b0;
                    box_x_next = XMAX - 10'd1;
                end else begin
                    box_x_next = box_x_reg + 10'd1;
                end
            end else begin
                if (box_x_reg == 10'd0) begin
                    dir_x_next = 1'b1;
                    box_x_next = 10'd1;
                end else begin
                    box_x_next = box_x_reg - 10'd1;
                end
            end
            if (dir_y_reg) begin
                if (box_y_reg == YMAX) begin
                    dir_y_next = 1'b0;
                    box_y_next = YMAX - 9'd1;
                end else begin
                    box_y_next = box_y_reg + 9'd1;
                end
            end else begin
                if (box_y_reg == 9'd0) begin
                    dir_y_next = 1'b1;
                    box_y_next = 9'd1;
                end else begin
                    box_y_next = box_y_reg - 9'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_reg     <= PAT_BARS;
            pending_reg     <= 1'b0;
            frame_count_reg <= 8'd0;
            box_x_reg       <= 10'd0;
            box_y_reg       <= 9'd0;
            dir_x_reg       <= 1'b1;
            dir_y_reg       <= 1'b1;
            vsync_prev_reg  <= SYNC_IDLE;
            hsync_out_reg   <= SYNC_IDLE;
            vsync_out_reg   <= SYNC_IDLE;
            pixel_reg       <= 3'd0;
        end else begin
            pattern_reg     <= pattern_next;
            pending_reg     <= pending_next;
            frame_count_reg <= frame_count_next;
            box_x_reg       <= box_x_next;
            box_y_reg       <= box_y_next;
            dir_x_reg       <= dir_x_next;
            dir_y_reg       <= dir_y_next;
            vsync_prev_reg  <= vsync_in;
            hsync_out_reg   <= hsync_in;
            vsync_out_reg   <= vsync_in;
            pixel_reg       <= pixel_next;
        end
    end

    assign pixel       = pixel_reg;
    assign hsync_out   = hsync_out_reg;
    assign vsync_out   = vsync_out_reg;
    assign mode        = pattern_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: a behavioural model predicts each cycle's outputs,
// a queue carries the predictions to the cycle where the DUT registers them.
module tb_vga_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] x;
    logic [8:0] y;
    logic       de, hs, vs, mn;
    logic [2:0] pixel;
    logic       hsync_out, vsync_out;
    logic [1:0] mode;
    logic [7:0] frame_count;

    vga_pattern_gen dut (
        .clk(clk), .rst_n(rst_n), .x_in(x), .y_in(y), .in_display(de),
        .hsync_in(hs), .vsync_in(vs), .mode_next(mn),
        .pixel(pixel), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .mode(mode), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] p;
        logic       h;
        logic       v;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int errors  = 0;

    int       m_mode, m_fc, m_bx, m_by;
    bit       m_pend, m_dx, m_dy, m_vprev;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_fc = 0; m_bx = 0; m_by = 0;
        m_pend = 0; m_dx = 1; m_dy = 1; m_vprev = 1;
        sb.delete();
    endtask

    function automatic int model_pix(input int px, input int py);
        int bar;
        case (m_mode)
            0: begin
                bar = (px >= 560) ? 7 : px / 80;
                return 7 - bar;
            end
            1: return (((px >> 5) & 1) != ((py >> 5) & 1)) ? 7 : 0;
            2: return (px >= m_bx && px < m_bx + 32 && py >= m_by && py < m_by + 32) ? 7 : 1;
            default: return (m_fc >> 5) & 7;
        endcase
    endfunction

    // Drives one cycle of inputs, predicts the outputs and advances the model.
    task automatic step(input int sx, input int sy, input bit sde, input bit shs,
                        input bit svs, input bit smn);
        exp_t e;
        bit   tick;
        x = 10'(sx); y = 9'(sy); de = sde; hs = shs; vs = svs; mn = smn;
        e.p = sde ? 3'(model_pix(sx, sy)) : 3'd0;
        e.h = shs;
        e.v = svs;
        sb.push_back(e);
        tick = !svs && m_vprev;
        m_vprev = svs;
        if (tick) begin
            m_fc = (m_fc + 1) % 256;
            if (m_dx) begin
                if (m_bx == 608) begin m_dx = 0; m_bx = 607; end else m_bx++;
            end else begin
                if (m_bx == 0) begin m_dx = 1; m_bx = 1; end else m_bx--;
            end
            if (m_dy) begin
                if (m_by == 448) begin m_dy = 0; m_by = 447; end else m_by++;
            end else begin
                if (m_by == 0) begin m_dy = 1; m_by = 1; end else m_by--;
            end
            if (m_pend || smn) m_mode = (m_mode + 1) % 4;
            m_pend = 0;
        end else if (smn) begin
            m_pend = 1;
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pixel", 16'(pixel), 16'(e.p));
        chk("hsync_out", 16'(hsync_out), 16'(e.h));
        chk("vsync_out", 16'(vsync_out), 16'(e.v));
        chk("mode", 16'(mode), 16'(m_mode));
        chk("frame_count", 16'(frame_count), 16'(m_fc));
    endtask

    task automatic probe(input string tag, input int px, input int py, input int exp);
        step(px, py, 1, 1, 1, 0);
        chk(tag, 16'(pixel), 16'(exp));
    endtask

    task automatic frame(input bit mn_tick);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0, mn_tick);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        // Reset held mid-line with active syncs driven
        rst_n = 1'b0;
        x = 10'd100; y = 9'd50; de = 1'b1; hs = 1'b0; vs = 1'b0; mn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pixel", 16'(pixel), 16'd0);
        chk("rst_hsync", 16'(hsync_out), 16'd1);
        chk("rst_vsync", 16'(vsync_out), 16'd1);
        chk("rst_mode", 16'(mode), 16'd0);
        chk("rst_frame_count", 16'(frame_count), 16'd0);
        hs = 1'b1; vs = 1'b1;
        release_reset();
        probe("first_pixel", 0, 100, 7);

        // Colour bars sweep with hsync activity
        for (int i = 0; i < 640; i++) step(i, 100, 1, (i % 37) >= 5, 1, 0);
        probe("bars_x0", 0, 100, 7);
        probe("bars_x79", 79, 100, 7);
        probe("bars_x80", 80, 100, 6);
        probe("bars_x480", 480, 100, 1);
        probe("bars_x559", 559, 100, 1);
        probe("bars_x639", 639, 100, 0);
        step(10, 100, 0, 1, 1, 0);
        chk("blank", 16'(pixel), 16'd0);
        step(10, 100, 1, 0, 1, 0);
        chk("hsync_delay", 16'(hsync_out), 16'd0);

        // Mode switching
        frame(0);
        step(5, 5, 0, 1, 1, 1);
        step(6, 5, 0, 1, 1, 0);
        step(7, 5, 0, 1, 1, 1);
        step(8, 5, 0, 1, 1, 1);
        chk("mode_held", 16'(mode), 16'd0);
        frame(0);
        chk("mode_one_step", 16'(mode), 16'd1);
        frame(1);
        chk("mode_tick_pulse", 16'(mode), 16'd2);
        frame(0);
        chk("pending_cleared", 16'(mode), 16'd2);
        frame(1);
        frame(1);
        chk("mode_wrap", 16'(mode), 16'd0);
        frame(1);
        chk("mode_check", 16'(mode), 16'd1);

        // Checkerboard
        probe("chk_0_0", 0, 0, 0);
        probe("chk_32_0", 32, 0, 7);
        probe("chk_32_32", 32, 32, 0);
        probe("chk_31_32", 31, 32, 7);

        // Asynchronous reset mid-frame with a pending request
        step(3, 3, 1, 1, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mode", 16'(mode), 16'd0);
        chk("async_pixel", 16'(pixel), 16'd0);
        release_reset();
        frame(0);
        chk("pending_reset", 16'(mode), 16'd0);

        // Bouncing box: restart so the box origin is known
        rst_n = 1'b0;
        #1;
        release_reset();
        frame(1);
        frame(1);
        for (int f = 2; f < 608; f++) begin
            frame(0);
            probe("box_in", m_bx, m_by, 7);
            probe("box_right", m_bx + 32, m_by, 1);
        end
        probe("box_608_in", 608, 288, 7);
        probe("box_608_left", 607, 288, 1);
        probe("box_608_corner", 639, 319, 7);
        probe("box_608_below", 608, 320, 1);
        frame(0);
        probe("box_607_in", 607, 287, 7);
        probe("box_607_edge", 639, 287, 1);
        probe("box_607_left", 606, 287, 1);
        for (int f = 609; f < 700; f++) begin
            frame(0);
            probe("box_in", m_bx, m_by, 7);
        end

        // Colour cycle and frame counter wrap
        rst_n = 1'b0;
        #1;
        release_reset();
        frame(1);
        frame(1);
        frame(1);
        probe("cycle_start", 0, 0, 0);
        while (m_fc != 255) begin
            frame(0);
            probe("cycle", 20, 20, model_pix(20, 20));
        end
        probe("cycle_255", 5, 5, 7);
        frame(0);
        chk("fc_wrap", 16'(frame_count), 16'd0);
        probe("cycle_wrapped", 5, 5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
